// File: rtl/uart_echo_checker.sv
// Echo checker: streams seed+n bytes to a UART transmitter and compares the looped-back
// receive stream. Define ECHO_TIMEOUT_EN to bound the wait for each echo.
module uart_echo_checker #(
  parameter int CLK_FRE    = 25,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [7:0]  seed,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [15:0] byte_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, END} state_t;

  state_t      r_state;
  logic [15:0] r_len;
  logic [7:0]  r_seed;
  logic [15:0] r_err_cnt;
  logic [15:0] r_byte_cnt;
  logic        r_pass;
  logic        r_timeout;

  state_t      w_state_next;
  logic [15:0] w_len_next;
  logic [7:0]  w_seed_next;
  logic [15:0] w_err_next;
  logic [15:0] w_byte_next;
  logic        w_pass_next;
  logic        w_tmo_next;
  logic        w_err_inc;
  logic        w_clear;
  logic        w_tmo_hit;
  logic [7:0]  w_expected;

  assign w_expected = r_seed + r_byte_cnt[7:0];

`ifdef ECHO_TIMEOUT_EN
  localparam int unsigned LIMIT = CLK_FRE * TIMEOUT_US;
  logic [31:0] r_tmo_cnt;

  // Counter restarts every time WAIT is entered because it is held at zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst || r_state != WAIT) r_tmo_cnt <= '0;
    else                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end

  assign w_tmo_hit = (r_state == WAIT) && (r_tmo_cnt == LIMIT - 32'd1);
`else
  // Without the timeout the clock/timeout parameters have no effect.
  localparam int LIMIT = CLK_FRE * TIMEOUT_US;
  assign w_tmo_hit = (LIMIT < 0) & 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_seed_next  = r_seed;
    w_byte_next  = r_byte_cnt;
    w_pass_next  = r_pass;
    w_tmo_next   = r_timeout;
    w_err_inc    = 1'b0;
    w_clear      = 1'b0;
    w_err_next   = r_err_cnt;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_len_next   = len;
          w_seed_next  = seed;
          w_byte_next  = 16'd0;
          w_pass_next  = 1'b0;
          w_tmo_next   = 1'b0;
          w_state_next = (len != 16'd0) ? SEND : END;
        end
      end
      SEND: begin
        // Anything arriving before the byte is even sent cannot be its echo.
        if (rx_data_valid) w_err_inc = 1'b1;
        if (tx_data_ready) w_state_next = WAIT;
      end
      WAIT: begin
        if (rx_data_valid) begin
          w_byte_next  = r_byte_cnt + 16'd1;
          w_err_inc    = (rx_data != w_expected);
          w_state_next = (w_byte_next == r_len) ? END : SEND;
        end else if (w_tmo_hit) begin
          w_tmo_next   = 1'b1;
          w_state_next = END;
        end
      end
      END:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    if (w_clear)                                  w_err_next = 16'd0;
    else if (w_err_inc && r_err_cnt != 16'hFFFF)  w_err_next = r_err_cnt + 16'd1;

    // Verdict is taken on END entry so it already reflects the final byte's compare.
    if (w_state_next == END && r_state != END)
      w_pass_next = (w_err_next == 16'd0) && !w_tmo_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= 16'd0;
      r_seed     <= 8'd0;
      r_err_cnt  <= 16'd0;
      r_byte_cnt <= 16'd0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_len      <= w_len_next;
      r_seed     <= w_seed_next;
      r_err_cnt  <= w_err_next;
      r_byte_cnt <= w_byte_next;
      r_pass     <= w_pass_next;
      r_timeout  <= w_tmo_next;
    end
  end

  assign tx_data       = (r_state == SEND) ? w_expected : 8'h00;
  assign tx_data_valid = (r_state == SEND);
  assign rx_data_ready = 1'b1;
  assign busy          = (r_state == SEND) || (r_state == WAIT);
  assign done          = (r_state == END);
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign err_cnt       = r_err_cnt;
  assign byte_cnt      = r_byte_cnt;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker: a vector table drives loopback runs, and short
// hand-written sequences cover reset, ignored starts and the echo timeout.
module tb_uart_echo_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [7:0]  seed;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] err_cnt;
  logic [15:0] byte_cnt;

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0] tx_log [16];

  uart_echo_checker #(.CLK_FRE(1), .TIMEOUT_US(20)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .seed(seed),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .byte_cnt(byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1);
  end

  // One run: corrupt_idx / withhold_idx of -1 mean none; exp_done_* of -1 mean unchecked.
  typedef struct {
    logic [7:0]  seed;
    logic [15:0] len;
    int          corrupt_idx;
    logic [7:0]  corrupt_val;
    int          withhold_idx;
    bit          stray;
    int          exp_ntx;
    logic [7:0]  exp_last;
    logic [15:0] exp_err;
    logic [15:0] exp_byte;
    bit          exp_pass;
    bit          exp_tmo;
    int          exp_done_at;
    int          exp_done_wait;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, done_at, n_tx, echo_due, wait_entry;
    logic [7:0] echo_byte, held, e;
    bit prev_valid, stray_done, hs;
    done_at = -1; n_tx = 0; echo_due = -1; wait_entry = -1;
    prev_valid = 1'b0; stray_done = 1'b0; echo_byte = 8'h00; held = 8'h00;
    seed = v.seed; len = v.len; start = 1'b1;
    tick();
    start = 1'b0; len = 16'd0; cyc = 1;
    while (cyc < 400 && done_at < 0) begin
      rx_data_valid = 1'b0; rx_data = 8'h00; tx_data_ready = 1'b0;
      if (done) begin
        done_at = cyc;
      end else begin
        if (prev_valid) begin
          chk({tag, "_tx_hold_valid"}, 32'(tx_data_valid), 32'd1);
          chk({tag, "_tx_hold_data"}, 32'(tx_data), 32'(held));
        end
        if (tx_data_valid) begin
          // Accept each byte on its second SEND cycle so valid must be held once.
          hs = prev_valid;
          tx_data_ready = hs;
          if (v.stray && !stray_done && !hs) begin
            rx_data_valid = 1'b1; rx_data = tx_data; stray_done = 1'b1;
          end
          if (hs) begin
            if (n_tx < 16) tx_log[n_tx] = tx_data;
            if (n_tx == v.withhold_idx) wait_entry = cyc + 1;
            else begin
              echo_due  = cyc + 5;
              echo_byte = (n_tx == v.corrupt_idx) ? v.corrupt_val : tx_data;
            end
            n_tx++;
          end
          prev_valid = !hs;
          held = tx_data;
        end else begin
          prev_valid = 1'b0;
        end
        if (cyc == echo_due) begin
          rx_data_valid = 1'b1; rx_data = echo_byte;
        end
        tick();
        cyc++;
      end
    end
    if (done_at < 0) begin
      n_checks++; n_errs++;
      $display("FAIL %s_bound: no done within 400 cycles, expected done", tag);
    end else begin
      $display("run %s: seed=%0h len=%0d done_at=%0d tx=%0d err=%0d bytes=%0d pass=%0d tmo=%0d",
               tag, v.seed, v.len, done_at, n_tx, err_cnt, byte_cnt, pass, timeout);
      chk({tag, "_ntx"}, 32'(n_tx), 32'(v.exp_ntx));
      if (n_tx > 0 && n_tx <= 16) chk({tag, "_last_tx"}, 32'(tx_log[n_tx-1]), 32'(v.exp_last));
      for (int i = 0; i < n_tx && i < 16; i++) begin
        e = v.seed + 8'(i);
        chk({tag, "_tx_seq"}, 32'(tx_log[i]), 32'(e));
      end
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
      chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(v.exp_byte));
      chk({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
      chk({tag, "_timeout"}, 32'(timeout), 32'(v.exp_tmo));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (v.exp_done_at >= 0) chk({tag, "_done_at"}, 32'(done_at), 32'(v.exp_done_at));
      if (v.exp_done_wait >= 0) chk({tag, "_done_after_wait"}, 32'(done_at - wait_entry), 32'(v.exp_done_wait));
      // A start coinciding with done must be dropped; done must last one cycle.
      start = 1'b1; len = 16'd1;
      tick();
      start = 1'b0; len = 16'd0;
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, "_start_at_done_busy"}, 32'(busy), 32'd0);
      chk({tag, "_start_at_done_tx"}, 32'(tx_data_valid), 32'd0);
      chk({tag, "_pass_hold"}, 32'(pass), 32'(v.exp_pass));
    end
  endtask

  vec_t vecs[6];
  vec_t vpost;
`ifdef ECHO_TIMEOUT_EN
  vec_t vtmo;
`endif

  initial begin
    // seed, len, corrupt_idx, corrupt_val, withhold_idx, stray, ntx, last, err, bytes, pass, tmo, done_at, done_wait
    vecs[0] = '{8'h10, 16'd4, -1, 8'h00, -1, 1'b0, 4, 8'h13, 16'd0, 16'd4, 1'b1, 1'b0, -1, -1};
    vecs[1] = '{8'hFE, 16'd3,  2, 8'h55, -1, 1'b0, 3, 8'h00, 16'd1, 16'd3, 1'b0, 1'b0, -1, -1};
    // len=0: done in the cycle right after start is sampled (second cycle counting the start cycle).
    vecs[2] = '{8'h33, 16'd0, -1, 8'h00, -1, 1'b0, 0, 8'h00, 16'd0, 16'd0, 1'b1, 1'b0,  1, -1};
    vecs[3] = '{8'h40, 16'd2, -1, 8'h00, -1, 1'b1, 2, 8'h41, 16'd1, 16'd2, 1'b0, 1'b0, -1, -1};
    vecs[4] = '{8'h20, 16'd3,  0, 8'h21, -1, 1'b0, 3, 8'h22, 16'd1, 16'd3, 1'b0, 1'b0, -1, -1};
    vecs[5] = '{8'h7F, 16'd1, -1, 8'h00, -1, 1'b0, 1, 8'h7F, 16'd0, 16'd1, 1'b1, 1'b0, -1, -1};
    vpost   = '{8'h01, 16'd1, -1, 8'h00, -1, 1'b0, 1, 8'h01, 16'd0, 16'd1, 1'b1, 1'b0, -1, -1};

    rst = 1'b1; start = 1'b0; len = 16'd0; seed = 8'h00;
    tx_data_ready = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rx_ready_tied", 32'(rx_data_ready), 32'd1);

    // Stray rx while idle is dropped.
    rx_data_valid = 1'b1; rx_data = 8'hAA;
    tick();
    rx_data_valid = 1'b0;
    chk("idle_rx_err_cnt", 32'(err_cnt), 32'd0);
    chk("idle_rx_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset clears a held pass and wins over a same-edge start.
    chk("pre_reset_pass", 32'(pass), 32'd1);
    rst = 1'b1; start = 1'b1; len = 16'd2; seed = 8'h09;
    tick();
    rst = 1'b0; start = 1'b0; len = 16'd0;
    chk("rst_vs_start_pass", 32'(pass), 32'd0);
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    $display("seq rst_vs_start: pass=%0d busy=%0d", pass, busy);

    // Reset while a byte is being offered.
    seed = 8'h80; len = 16'd5; start = 1'b1;
    tick();
    start = 1'b0; len = 16'd0;
    chk("mid_tx_valid", 32'(tx_data_valid), 32'd1);
    chk("mid_tx_data", 32'(tx_data), 32'h80);
    rst = 1'b1; tx_data_ready = 1'b1; rx_data_valid = 1'b1; rx_data = 8'h13;
    tick();
    rst = 1'b0; tx_data_ready = 1'b0; rx_data_valid = 1'b0;
    chk("midrst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_byte_cnt", 32'(byte_cnt), 32'd0);
    $display("seq mid_reset: busy=%0d err=%0d bytes=%0d", busy, err_cnt, byte_cnt);
    run_vec(vpost, "post_reset");

`ifdef ECHO_TIMEOUT_EN
    vtmo = '{8'h50, 16'd3, -1, 8'h00, 1, 1'b0, 2, 8'h51, 16'd0, 16'd1, 1'b0, 1'b1, -1, 20};
    run_vec(vtmo, "timeout");
    // An echo on the final cycle of the wait window still counts.
    seed = 8'h66; len = 16'd1; start = 1'b1; tx_data_ready = 1'b1;
    tick();
    start = 1'b0; len = 16'd0;
    tick();
    tx_data_ready = 1'b0;
    repeat (19) tick();
    chk("limit_busy", 32'(busy), 32'd1);
    rx_data_valid = 1'b1; rx_data = 8'h66;
    tick();
    rx_data_valid = 1'b0;
    chk("limit_done", 32'(done), 32'd1);
    chk("limit_timeout", 32'(timeout), 32'd0);
    chk("limit_pass", 32'(pass), 32'd1);
    chk("limit_byte_cnt", 32'(byte_cnt), 32'd1);
    $display("seq limit_echo: done=%0d tmo=%0d pass=%0d", done, timeout, pass);
    tick();
`else
    // Without the timeout a missing echo just keeps the run waiting.
    seed = 8'h60; len = 16'd1; start = 1'b1; tx_data_ready = 1'b1;
    tick();
    start = 1'b0; len = 16'd0;
    tick();
    tx_data_ready = 1'b0;
    repeat (60) tick();
    chk("notmo_busy", 32'(busy), 32'd1);
    chk("notmo_done", 32'(done), 32'd0);
    chk("notmo_timeout", 32'(timeout), 32'd0);
    rx_data_valid = 1'b1; rx_data = 8'h60;
    tick();
    rx_data_valid = 1'b0;
    chk("notmo_late_done", 32'(done), 32'd1);
    chk("notmo_late_pass", 32'(pass), 32'd1);
    chk("notmo_late_byte_cnt", 32'(byte_cnt), 32'd1);
    $display("seq no_timeout: done=%0d pass=%0d bytes=%0d", done, pass, byte_cnt);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_echo_checker.md
UART_ECHO_CHECKER -- requirements
Module: uart_echo_checker

Interface
REQ-001 SHALL have parameter CLK_FRE, default 25, clock frequency in MHz.
REQ-002 SHALL have parameter TIMEOUT_US, default 1000, maximum wait for each echoed byte in microseconds.
REQ-003 SHALL have port clk  input  1  sole clock; one clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a test run.
REQ-006 SHALL have port len  input  16  number of bytes in the run, sampled at start.
REQ-007 SHALL have port seed  input  8  first pattern byte, sampled at start.
REQ-008 SHALL have port tx_data  output  8  byte to uart_tx.
REQ-009 SHALL have port tx_data_valid  output  1  tx_data is valid.
REQ-010 SHALL have port tx_data_ready  input  1  uart_tx accepts the byte.
REQ-011 SHALL have port rx_data  input  8  byte from uart_rx.
REQ-012 SHALL have port rx_data_valid  input  1  rx_data is valid.
REQ-013 SHALL have port rx_data_ready  output  1  checker accepts the rx byte.
REQ-014 SHALL have port busy  output  1  run in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-016 SHALL have port pass  output  1  result of the last run, valid from done onward.
REQ-017 SHALL have port timeout  output  1  last run ended by timeout.
REQ-018 SHALL have port err_cnt  output  16  mismatching or stray bytes in the current or last run.
REQ-019 SHALL have port byte_cnt  output  16  echoes received in the current or last run.

Function
REQ-020 SHALL implement the states IDLE, SEND, WAIT and END.
- rx_data_ready SHALL be tied to 1; rx bytes are never back-pressured.
REQ-021 IDLE: on start=1, the block SHALL latch len and seed, and SHALL clear err_cnt, byte_cnt, pass and timeout.
- Next state SHALL be SEND when len!=0, else END.
- start SHALL be ignored in every state except IDLE.
REQ-022 SEND: the block SHALL hold tx_data_valid=1 and tx_data=expected, where expected = seed + byte_cnt, mod 256, wrapping 0xFF->0x00.
- The block SHALL move to WAIT on the cycle with tx_data_valid & tx_data_ready.
- tx_data_valid SHALL be deasserted the following cycle.
REQ-023 WAIT: on rx_data_valid, the block SHALL compare rx_data with expected.
- A mismatch SHALL increment err_cnt; err_cnt saturates at 0xFFFF.
- byte_cnt SHALL increment on every received byte.
- Next state SHALL be END if byte_cnt+1==len, else SEND.
REQ-024 An rx_data_valid in SEND SHALL count as a stray byte: err_cnt increments, byte_cnt does not.
- An rx_data_valid in IDLE or END SHALL be dropped without effect.
REQ-025 END: done=1 for exactly one cycle, then IDLE.
- pass SHALL be set to (err_cnt==0 && !timeout), including the effect of any same-cycle increment.
- pass SHALL hold until the next start.
REQ-026 busy SHALL be 1 in SEND and WAIT, and 0 in IDLE and END.
REQ-027 There SHALL be one outstanding byte at most: a new byte is not sent until the previous echo arrives or the run ends.
REQ-028 A start on the same cycle as done SHALL be ignored, because the block is not yet in IDLE.

Reset
REQ-029 With rst=1 at a clk edge, the block SHALL enter IDLE from any state, including mid-run.
- tx_data=0, tx_data_valid=0, busy=0, done=0, pass=0, timeout=0, err_cnt=0, byte_cnt=0.
- The timeout counter SHALL be cleared.
REQ-030 Reset SHALL take priority over start and over every handshake input on the same edge.

Configuration
REQ-031 Macro ECHO_TIMEOUT_EN SHALL select the timeout feature.
- Defined: a counter runs in WAIT, cleared on WAIT entry, limit CLK_FRE*TIMEOUT_US cycles. On reaching the limit, the block SHALL set timeout=1 and go to END, so pass=0.
- An rx byte on the limit cycle SHALL win: it is processed normally and no timeout occurs.
- Not defined: no counter; WAIT persists until a byte arrives; timeout tied to 0.

Verification
REQ-032 Loopback (rx follows tx 5 cycles later), seed=0x10, len=4 -> bytes 0x10,0x11,0x12,0x13 sent; done pulse; pass=1; err_cnt=0; byte_cnt=4.
REQ-033 seed=0xFE, len=3, third echo corrupted to 0x55 -> tx 0xFE,0xFF,0x00; err_cnt=1; pass=0.
REQ-034 len=0 -> no tx_data_valid; done 2 cycles after start; pass=1; byte_cnt=0.
REQ-035 ECHO_TIMEOUT_EN, CLK_FRE=1, TIMEOUT_US=20, echo withheld on byte 2 -> done 20 cycles after WAIT entry; timeout=1; byte_cnt=1; pass=0.
REQ-036 rst asserted while tx_data_valid=1 mid-run -> next cycle: all outputs at reset values; a new start with len=1 completes with pass=1.
REQ-037 Stray rx byte injected during SEND, len=2, correct echoes -> err_cnt=1; byte_cnt=2; pass=0.
